// File: rtl/btn_debounce_rpt.sv
// Push-button conditioner: 2-FF synchroniser, tick-qualified debounce and
// press/release/auto-repeat strobes, all registered on clk_24M.
module btn_debounce_rpt #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned STABLE_TICKS = 2,
    parameter int unsigned REPEAT_DELAY = 10,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic             clk_24M,
    input  logic             reset,
    input  logic             clk_debounce,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RCNT_W = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);
    localparam bit                RPT_EN     = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0]  raw_norm_c;
    logic [N_BTN-1:0]  fall_c;
    logic [N_BTN-1:0]  sync_meta;
    logic [N_BTN-1:0]  sync;
    logic [CNT_W-1:0]  cnt   [N_BTN];
    logic [RCNT_W-1:0] rcnt  [N_BTN];
    rpt_state_t        state [N_BTN];

    assign raw_norm_c = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Level is about to drop this edge; a repeat here would overlap the release.
    always_comb begin
        fall_c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            fall_c[i] = clk_debounce && btn_level[i] && !sync[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_24M) begin
        if (reset) begin
            sync_meta   <= '0;
            sync        <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i]   <= '0;
                rcnt[i]  <= '0;
                state[i] <= IDLE;
            end
        end else begin
            sync_meta   <= raw_norm_c;
            sync        <= sync_meta;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                // Debounce: a run of STABLE_TICKS disagreeing tick samples flips the level.
                if (clk_debounce) begin
                    if (sync[i] == btn_level[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        btn_level[i]   <= sync[i];
                        btn_press[i]   <= sync[i];
                        btn_release[i] <= !sync[i];
                        cnt[i]         <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end

                case (state[i])
                    IDLE: begin
                        if (RPT_EN && btn_press[i]) begin
                            state[i] <= HOLD;
                            rcnt[i]  <= '0;
                        end
                    end
                    HOLD: begin
                        if (btn_release[i]) begin
                            state[i] <= IDLE;
                        end else if (clk_debounce) begin
                            if (rcnt[i] == DELAY_LAST) begin
                                btn_repeat[i] <= !fall_c[i];
                                rcnt[i]       <= '0;
                                state[i]      <= RPT;
                            end else begin
                                rcnt[i] <= rcnt[i] + RCNT_W'(1);
                            end
                        end
                    end
                    RPT: begin
                        if (btn_release[i]) begin
                            state[i] <= IDLE;
                        end else if (clk_debounce) begin
                            if (rcnt[i] == RATE_LAST) begin
                                btn_repeat[i] <= !fall_c[i];
                                rcnt[i]       <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RCNT_W'(1);
                            end
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Self-checking bench for btn_debounce_rpt: directed scenarios plus random
// button activity, compared cycle by cycle with a tick-counting reference model.
module tb_btn_debounce_rpt;

    localparam int ST     = 2;
    localparam int RD     = 3;
    localparam int RR     = 2;
    localparam int TICK_P = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] raw0, raw1;
    logic [3:0] lvl0, prs0, rel0, rpt0;
    logic [3:0] lvl1, prs1, rel1, rpt1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit last_tick;

    // Reference state: sync pipeline, disagreement run length, ticks since press.
    bit         m_q1    [2][4];
    bit         m_q2    [2][4];
    bit         m_lvl   [2][4];
    int         m_run   [2][4];
    bit         m_armed [2][4];
    int         m_since [2][4];
    logic [3:0] exp_lvl [2];
    logic [3:0] exp_prs [2];
    logic [3:0] exp_rel [2];
    logic [3:0] exp_rpt [2];

    always #5 clk = ~clk;

    btn_debounce_rpt #(
        .N_BTN(4), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk_24M(clk), .reset(reset), .clk_debounce(tick), .btn_raw(raw0),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_repeat(rpt0)
    );

    btn_debounce_rpt #(
        .N_BTN(4), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk_24M(clk), .reset(reset), .clk_debounce(tick), .btn_raw(raw1),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_repeat(rpt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before that edge.
    task automatic model_step();
        logic [3:0] nrm;
        bit s, np, nr, nrp, fall;
        for (int inst = 0; inst < 2; inst++) begin
            nrm = (inst == 0) ? raw0 : ~raw1;
            for (int b = 0; b < 4; b++) begin
                if (reset) begin
                    m_q1[inst][b] = 1'b0;  m_q2[inst][b] = 1'b0;  m_lvl[inst][b] = 1'b0;
                    m_run[inst][b] = 0;    m_armed[inst][b] = 1'b0; m_since[inst][b] = 0;
                    exp_lvl[inst][b] = 1'b0; exp_prs[inst][b] = 1'b0;
                    exp_rel[inst][b] = 1'b0; exp_rpt[inst][b] = 1'b0;
                end else begin
                    s = m_q2[inst][b];
                    m_q2[inst][b] = m_q1[inst][b];
                    m_q1[inst][b] = nrm[b];
                    np = 1'b0; nr = 1'b0; nrp = 1'b0; fall = 1'b0;
                    if (tick) begin
                        if (s != m_lvl[inst][b]) begin
                            m_run[inst][b]++;
                            if (m_run[inst][b] == ST) begin
                                m_lvl[inst][b] = s;
                                m_run[inst][b] = 0;
                                np = s; nr = !s; fall = !s;
                            end
                        end else begin
                            m_run[inst][b] = 0;
                        end
                    end
                    if (exp_rel[inst][b]) begin
                        m_armed[inst][b] = 1'b0;
                    end else if (m_armed[inst][b] && tick) begin
                        m_since[inst][b]++;
                        if (!fall && m_since[inst][b] >= RD && ((m_since[inst][b] - RD) % RR) == 0)
                            nrp = 1'b1;
                    end
                    if (exp_prs[inst][b]) begin
                        m_armed[inst][b] = 1'b1;
                        m_since[inst][b] = 0;
                    end
                    exp_lvl[inst][b] = m_lvl[inst][b];
                    exp_prs[inst][b] = np;
                    exp_rel[inst][b] = nr;
                    exp_rpt[inst][b] = nrp;
                end
            end
        end
    endtask

    // One clock: model update, full output comparison, then drive next tick.
    task automatic step();
        @(posedge clk);
        #1;
        last_tick = tick;
        model_step();
        cyc++;
        chk("lvl_hi", 32'(lvl0), 32'(exp_lvl[0]));
        chk("prs_hi", 32'(prs0), 32'(exp_prs[0]));
        chk("rel_hi", 32'(rel0), 32'(exp_rel[0]));
        chk("rpt_hi", 32'(rpt0), 32'(exp_rpt[0]));
        chk("lvl_lo", 32'(lvl1), 32'(exp_lvl[1]));
        chk("prs_lo", 32'(prs1), 32'(exp_prs[1]));
        chk("rel_lo", 32'(rel1), 32'(exp_rel[1]));
        chk("rpt_lo", 32'(rpt1), 32'(exp_rpt[1]));
        tick = ((cyc % TICK_P) == TICK_P - 1);
    endtask

    initial begin
        int n, k, tk, first, dbl, nrel;
        bit prev;
        reset = 1'b1; tick = 1'b0; raw0 = 4'hF; raw1 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            exp_lvl[i] = '0; exp_prs[i] = '0; exp_rel[i] = '0; exp_rpt[i] = '0;
        end

        // 1: reset with all buttons held, then qualification of all four
        repeat (5) begin
            step();
            chk("t1_rst_outs", 32'({lvl0, prs0, rel0, rpt0}), 32'h0);
        end
        reset = 1'b0;
        n = 0;
        repeat (40) begin
            step();
            if (prs0 == 4'hF) n++;
        end
        chk("t1_press_once", 32'(n), 32'd1);
        chk("t1_level", 32'(lvl0), 32'hF);

        // 2: release all, then bounce bit 0 and hold it
        raw0 = 4'h0;
        repeat (40) step();
        chk("t2_released", 32'(lvl0), 32'h0);
        for (int c = 0; c < 60; c++) begin
            raw0[0] = ((c / 7) % 2) == 0;
            step();
        end
        raw0[0] = 1'b1;
        n = 0;
        repeat (40) begin
            step();
            if (prs0[0]) n++;
        end
        chk("t2_level0", 32'(lvl0[0]), 32'd1);
        chk("t2_press_le1", 32'(n <= 1), 32'd1);

        // 3: hold bit 1 and watch the repeat cadence
        raw0[1] = 1'b1;
        k = 0;
        while (!prs0[1] && k < 100) begin step(); k++; end
        chk("t3_press_seen", 32'(prs0[1]), 32'd1);
        n = 0; tk = 0; first = -1; dbl = 0; prev = 1'b0;
        repeat (12 * TICK_P) begin
            step();
            if (last_tick) tk++;
            if (rpt0[1]) begin
                n++;
                if (first < 0) first = tk;
                if (prs0[1]) dbl++;
            end
            if (rpt0[1] && prev) dbl++;
            prev = rpt0[1];
        end
        chk("t3_first_rpt_tick", 32'(first), 32'(RD));
        chk("t3_rpt_count", 32'(n), 32'd5);
        chk("t3_rpt_1cycle", 32'(dbl), 32'd0);

        // 4: release while in RPT; level falls on a tick that would otherwise repeat
        repeat (TICK_P) step();
        raw0[1] = 1'b0;
        n = 0; nrel = 0;
        repeat (6 * TICK_P) begin
            step();
            if (rpt0[1]) n++;
            if (rel0[1]) nrel++;
        end
        chk("t4_release_once", 32'(nrel), 32'd1);
        chk("t4_no_rpt_after", 32'(n), 32'd0);

        // 5: reset while bit 2 is held in HOLD, then re-qualification
        raw0[2] = 1'b1;
        k = 0;
        while (!prs0[2] && k < 100) begin step(); k++; end
        chk("t5_press_seen", 32'(prs0[2]), 32'd1);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("t5_rst_hi", 32'({lvl0, prs0, rel0, rpt0}), 32'h0);
        chk("t5_rst_lo", 32'({lvl1, prs1, rel1, rpt1}), 32'h0);
        reset = 1'b0;
        n = 0; nrel = 0;
        repeat (60) begin
            step();
            if (prs0[2]) n++;
            if (rel0[2]) nrel++;
        end
        chk("t5_repress", 32'(n), 32'd1);
        chk("t5_no_release", 32'(nrel), 32'd0);

        // 6: active-low instance idles released, bit 3 pulled low
        chk("t6_idle_level", 32'(lvl1), 32'h0);
        raw1[3] = 1'b0;
        n = 0;
        repeat (40) begin
            step();
            if (prs1 == 4'h8) n++;
        end
        chk("t6_press3", 32'(n), 32'd1);
        chk("t6_level3", 32'(lvl1), 32'h8);

        // Random activity on both instances with rare resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) raw0[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) raw1[$urandom_range(0, 3)] ^= 1'b1;
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
